// File: rtl/dff_pipeline_stall.sv
// Parametrised WIDTH-bit, DEPTH-stage register pipeline with per-stage valid
// bits, valid/ready backpressure, bubble collapsing, flush and an occupancy count.
// Stage 0 takes words from the producer, and stage DEPTH-1 drives q.
module dff_pipeline_stall #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              d,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              q,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH:0]   w_rdy;
  logic             w_chain;
  logic [DEPTH-1:0] w_srcVld;
  logic [WIDTH-1:0] w_srcData [DEPTH];
  logic             w_accept;
  logic             w_transfer;

  // Ready chain: a stage can load when it is empty or everything downstream can move.
  // A running chain variable keeps the vector free of self-reads.
  always_comb begin
    w_rdy          = '0;
    w_chain        = out_ready;
    w_rdy[DEPTH]   = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_chain  = !r_vld[i] | w_chain;
      w_rdy[i] = w_chain;
    end
  end

  // Source of each stage: the producer for stage 0, the previous stage otherwise.
  always_comb begin
    w_srcVld[0]  = in_valid;
    w_srcData[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      w_srcVld[i]  = r_vld[i-1];
      w_srcData[i] = r_data[i-1];
    end
  end

  assign in_ready   = w_rdy[0] & !flush & !rst;
  assign out_valid  = r_vld[DEPTH-1] & !flush;
  assign q          = r_data[DEPTH-1];
  assign occupancy  = r_occ;
  assign w_accept   = in_valid & in_ready;
  assign w_transfer = out_valid & out_ready;

  // Stage registers and occupancy: reset beats flush, which beats normal advance.
  // Flush clears only the valid bits, leaving the data registers untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
    end else if (flush) begin
      r_vld <= '0;
      r_occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_vld[i] <= w_srcVld[i];
          if (w_srcVld[i]) begin
            r_data[i] <= w_srcData[i];
          end
        end
      end
      r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(w_transfer);
    end
  end

endmodule
